// File: rtl/nibble_serial_addsub_if.sv
// nibble_serial_addsub_if: start/busy/done handshake and operand/result bus for the nibble-serial add/sub unit
interface nibble_serial_addsub_if #(parameter int WIDTH = 16);
  logic start;
  logic sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic busy;
  logic done;
  logic [WIDTH-1:0] S;
  logic Cout;
  logic overflow;
  modport master (output start, sub, A, B, input busy, done, S, Cout, overflow);
  modport slave (input start, sub, A, B, output busy, done, S, Cout, overflow);
endinterface

// File: rtl/nibble_serial_addsub.sv
// nibble_serial_addsub: WIDTH-bit add/sub, one 4-bit carry-lookahead nibble per clock, LSB first
module nibble_serial_addsub #(parameter int WIDTH = 16) (
  input logic clk,
  input logic rst,
  nibble_serial_addsub_if.slave bus
);
  localparam int N = WIDTH / 4;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, s_q, s_d;
  logic [KW-1:0] k_q, k_d;
  logic c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [3:0] x, y, p, g;
  logic c1, c2, c3, c4;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    k_d = k_q;
    r_d = r_q;
    s_d = s_q;
    cout_d = cout_q;
    ovf_d = ovf_q;
    x = a_q[4*k_q +: 4];
    y = b_q[4*k_q +: 4];
    p = x ^ y;
    g = x & y;
    c1 = g[0] | (p[0] & c_q);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_q);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_q);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & c_q);
    if (state_q == RUN) begin
      r_d[4*k_q +: 4] = p ^ {c3, c2, c1, c_q};
      c_d = c4;
      k_d = k_q + 1'b1;
      if (k_q == KW'(N - 1)) begin
        state_d = DONE;
        s_d = r_d;
        cout_d = c4;
        ovf_d = c4 ^ c3;
      end
    end else begin
      state_d = bus.start ? RUN : IDLE;
      if (bus.start) begin
        a_d = bus.A;
        b_d = bus.sub ? ~bus.B : bus.B;
        c_d = bus.sub;
        k_d = '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      r_q <= '0;
      s_q <= '0;
      k_q <= '0;
      c_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      r_q <= r_d;
      s_q <= s_d;
      k_q <= k_d;
      c_q <= c_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
    end
  end
  assign bus.busy = state_q == RUN;
  assign bus.done = state_q == DONE;
  assign bus.S = s_q;
  assign bus.Cout = cout_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// tb_nibble_serial_addsub: directed self-checking bench for the 16-bit nibble-serial add/sub unit
module tb_nibble_serial_addsub;
  localparam int WIDTH = 16;
  localparam int N = WIDTH / 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  int done_seen;
  nibble_serial_addsub_if #(.WIDTH(WIDTH)) bus ();
  nibble_serial_addsub #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic [15:0] es, input logic ec, input logic eo);
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.sub = s;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("busy_run", {bus.busy, bus.done}, 2'b10);
      @(negedge clk);
    end
    chk("done_pulse", {bus.busy, bus.done}, 2'b01);
    chk("result_s", bus.S, es);
    chk("result_cout", bus.Cout, ec);
    chk("result_ovf", bus.overflow, eo);
    @(negedge clk);
    chk("done_end", {bus.busy, bus.done}, 2'b00);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.sub = 1'b0;
    bus.A = '0;
    bus.B = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_flags", {bus.busy, bus.done}, 2'b00);
    chk("reset_s", bus.S, 16'h0000);
    chk("reset_cout_ovf", {bus.Cout, bus.overflow}, 2'b00);
    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    @(negedge clk);
    bus.A = 16'h0001;
    bus.B = 16'h0001;
    bus.sub = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.A = 16'hAAAA;
    bus.B = 16'h5555;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("ignore_busy", {bus.busy, bus.done}, 2'b10);
    @(negedge clk);
    chk("ignore_busy2", {bus.busy, bus.done}, 2'b10);
    @(negedge clk);
    chk("ignore_done", {bus.busy, bus.done}, 2'b01);
    chk("ignore_s", bus.S, 16'h0002);
    bus.A = 16'h0010;
    bus.B = 16'h0020;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("b2b_busy", {bus.busy, bus.done}, 2'b10);
      @(negedge clk);
    end
    chk("b2b_done", {bus.busy, bus.done}, 2'b01);
    chk("b2b_s", bus.S, 16'h0030);
    @(negedge clk);
    bus.A = 16'h1111;
    bus.B = 16'h2222;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_flags", {bus.busy, bus.done}, 2'b00);
    chk("rst_s", bus.S, 16'h0000);
    chk("rst_cout_ovf", {bus.Cout, bus.overflow}, 2'b00);
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done) done_seen++;
      @(negedge clk);
    end
    chk("rst_no_done", done_seen, 0);
    run_op(16'h00FF, 16'h0101, 1'b0, 16'h0200, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
